// File: rtl/proc_control.sv
// Control unit for the 9-bit simple processor: step-counter FSM that latches an
// instruction from DIN and drives the datapath enables over up to four steps.

module dec3to8 (
   input  logic [2:0] w,
   input  logic       en,
   output logic [7:0] y
);

   // Field value 000 selects bit 7, so R0 sits in the MSB of the one-hot vector.
   always_comb begin
      y = '0;
      if (en) y[3'd7 - w] = 1'b1;
   end

endmodule

module proc_control (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Run,
   input  logic [8:0] DIN,
   output logic       IRin,
   output logic [7:0] Rin,
   output logic [7:0] Rout,
   output logic       Ain,
   output logic       Gin,
   output logic       Gout,
   output logic       DINout,
   output logic       AddSub,
   output logic       Done,
   output logic [1:0] Tstep
);

   localparam logic [1:0] T0 = 2'd0;
   localparam logic [1:0] T1 = 2'd1;
   localparam logic [1:0] T2 = 2'd2;
   localparam logic [1:0] T3 = 2'd3;

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;

   logic [1:0] step;
   logic [1:0] nextstep;
   logic [8:0] ir;
   logic [7:0] xsel;
   logic [7:0] ysel;
   logic       alu;

   dec3to8 decx (.w(ir[5:3]), .en(1'b1), .y(xsel));
   dec3to8 decy (.w(ir[2:0]), .en(1'b1), .y(ysel));

   assign alu   = (ir[8:6] == OP_ADD) || (ir[8:6] == OP_SUB);
   assign Tstep = step;

   // Next step is decided from the ungated Done; reset then clears every
   // control output so nothing reaches the datapath while Reset is high.
   always_comb begin
      IRin     = 1'b0;
      Rin      = '0;
      Rout     = '0;
      Ain      = 1'b0;
      Gin      = 1'b0;
      Gout     = 1'b0;
      DINout   = 1'b0;
      AddSub   = 1'b0;
      Done     = 1'b0;
      nextstep = step + 2'd1;
      case (step)
         T0: begin
            IRin     = Run;
            nextstep = Run ? T1 : T0;
         end
         T1: begin
            case (ir[8:6])
               OP_MV: begin
                  Rout = ysel;
                  Rin  = xsel;
                  Done = 1'b1;
               end
               OP_MVI: begin
                  DINout = 1'b1;
                  Rin    = xsel;
                  Done   = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  Rout = xsel;
                  Ain  = 1'b1;
               end
               default: Done = 1'b1;
            endcase
         end
         T2: begin
            if (alu) begin
               Rout   = ysel;
               Gin    = 1'b1;
               AddSub = ir[6];
            end
         end
         default: begin
            if (alu) begin
               Gout = 1'b1;
               Rin  = xsel;
               Done = 1'b1;
            end
         end
      endcase
      if (Done) nextstep = T0;
      if (Reset) begin
         IRin   = 1'b0;
         Rin    = '0;
         Rout   = '0;
         Ain    = 1'b0;
         Gin    = 1'b0;
         Gout   = 1'b0;
         DINout = 1'b0;
         AddSub = 1'b0;
         Done   = 1'b0;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         step <= T0;
         ir   <= '0;
      end else begin
         step <= nextstep;
         if (IRin) ir <= DIN;
      end
   end

endmodule

// File: doc/proc_control.md
# proc_control

Control unit for the 9-bit simple processor: a step-counter FSM that latches an instruction word from `DIN` and sequences the datapath (register file R0–R7, A, G, adder/subtractor, shared bus) over up to four clock steps. It decodes the X and Y register fields with two `dec3to8` instances into one-hot `Rin`/`Rout` enables. It signals completion with `Done`. It is the only driver of bus-select and register-load enables in the processor top level.

## Interface
- No parameters. Instruction width is fixed at 9; register count is fixed at 8.

Ports:
- `Clock`  in  1  single clock; all state updates on the rising edge
- `Reset`  in  1  synchronous, active-high; overrides all other inputs
- `Run`  in  1  start request; sampled only in step T0
- `DIN`  in  9  instruction word `{III, XXX, YYY}`; opcode `[8:6]`, X `[5:3]`, Y `[2:0]`
- `IRin`  out  1  load IR from `DIN` this cycle
- `Rin`  out  8  one-hot register load enable; bit 7 = R0 … bit 0 = R7
- `Rout`  out  8  one-hot register-to-bus select; same bit mapping as `Rin`
- `Ain`  out  1  load A from bus
- `Gin`  out  1  load G from adder output
- `Gout`  out  1  drive G onto bus
- `DINout`  out  1  drive `DIN` onto bus (immediate)
- `AddSub`  out  1  0 = add, 1 = subtract
- `Done`  out  1  instruction completes at the end of this cycle
- `Tstep`  out  2  current step (0–3), for debug and verification

## Operation
- Internal state:
  - 2-bit step counter `Tstep`.
  - 9-bit IR, loaded from `DIN` on the edge where `IRin` = 1.
- X one-hot = `dec3to8(IR[5:3], 1)`; Y one-hot = `dec3to8(IR[2:0], 1)`. Field value 000 maps to bit 7.
- All outputs are combinational from `Tstep`, IR and `Run`. Every output is 0 unless listed below.
- T0 (idle):
  - `IRin` = `Run & ~Reset`.
  - Next step is T1 if `Run`, else T0.
- Opcode 000, mv Rx,Ry — T1: `Rout`=Y, `Rin`=X, `Done`=1.
- Opcode 001, mvi Rx,#D — T1: `DINout`=1, `Rin`=X, `Done`=1. The immediate is the `DIN` value present during T1.
- Opcode 010 add / 011 sub (Rx ← Rx ± Ry):
  - T1: `Rout`=X, `Ain`=1.
  - T2: `Rout`=Y, `Gin`=1, `AddSub`=opcode[0].
  - T3: `Gout`=1, `Rin`=X, `Done`=1.
- Opcodes 100–111 (reserved) — T1: `Done`=1 only, no loads, no bus driver.
- On any edge where `Done`=1, next step is T0. Otherwise the step increments.
- `Run` is ignored outside T0. A new instruction cannot start in the same cycle `Done` is asserted.
- Bus invariant: at most one of {any `Rout` bit, `Gout`, `DINout`} is asserted in any cycle.
- At most one `Rin` bit is asserted per cycle.
- X = Y is legal:
  - mv R3,R3 asserts `Rout` and `Rin` bit 4 together.
  - add R3,R3 doubles R3.

## Timing
- Reset:
  - Reset edge forces `Tstep`=0 and IR=9'b0.
  - While `Reset`=1, all outputs are 0, including `IRin`.
  - Reset mid-instruction (T1–T3) aborts it. No `Done` is produced for the aborted instruction.
- Latency, counted from the T0 cycle with `Run`=1:
  - mv, mvi, reserved opcodes: `Done` in cycle 2 (T1).
  - add, sub: `Done` in cycle 4 (T3).
- Throughput: next instruction can be issued in the cycle after `Done`, when T0 is re-entered.
- `Tstep` never reaches 2 or 3 for non-ALU opcodes.
- The counter never wraps 3→0 except via `Done`.
- `Run` held high continuously issues back-to-back instructions, with one T0 cycle between them.

## Test plan
- Reset then idle: `Reset`=1 for 2 cycles, then `Run`=0 for 5 cycles.
  - Expect `Tstep`=0 and all outputs 0 throughout.
- mvi R2: T0 `Run`=1, `DIN`=9'b001_010_000.
  - T0: `IRin`=1.
  - T1: `DINout`=1, `Rin`=8'b00100000, `Done`=1.
  - Then `Tstep`=0.
- add R1,R6: `DIN`=9'b010_001_110.
  - T1: `Rout`=8'b01000000, `Ain`=1.
  - T2: `Rout`=8'b00000010, `Gin`=1, `AddSub`=0.
  - T3: `Gout`=1, `Rin`=8'b01000000, `Done`=1.
- sub R7,R0: `DIN`=9'b011_111_000.
  - T2: `AddSub`=1, `Rout`=8'b10000000.
  - T3: `Rin`=8'b00000001, `Done`=1.
- Reset mid-add: assert `Reset` during T2.
  - Next cycle: `Tstep`=0, IR=0, no `Done`.
  - Next `Run` starts a fresh instruction correctly.
- Back-to-back and protocol checks:
  - `Run` held high with mv R0,R5 then reserved opcode 9'b111_000_000.
    - `Done` in T1 of each, with one T0 cycle between.
    - Reserved opcode asserts no `Rin`/`Rout`/`Gout`/`DINout`.
  - `Run` toggled during T1–T3 has no effect.
  - Bus invariant is asserted in every cycle.
